// File: rtl/ex_div_pkg.sv
// Shared state encodings and control constants for the EX-stage radix-2 divider.
package ex_div_pkg;

   typedef enum logic [1:0] {
      DIV_FREE    = 2'b00,
      DIV_BY_ZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_t;

   localparam logic RST_ENABLE           = 1'b1;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/ex_div_if.sv
// Request/result bundle between the EX stage (master) and the multi-cycle divider (slave).
interface ex_div_if #(parameter int DATA_W = 32);

   logic                  signed_div_i;
   logic [DATA_W-1:0]     opdata1_i;
   logic [DATA_W-1:0]     opdata2_i;
   logic                  start_i;
   logic                  annul_i;
   logic [2*DATA_W-1:0]   result_o;
   logic                  ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );

endinterface

// File: rtl/ex_div.sv
// Radix-2 restoring divider, one quotient bit per cycle, DIV/DIVU.
// Result is {remainder, quotient}; ready_o stays high until the EX stage drops start_i.
module ex_div
   import ex_div_pkg::*;
#(
   parameter int DATA_W = 32
)(
   input  logic     clk,
   input  logic     rst,
   ex_div_if.slave  dif
);

   localparam int CNT_W = $clog2(DATA_W) + 1;

   div_state_t            state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [DATA_W-1:0]     rem, rem_nxt;
   logic [DATA_W-1:0]     dvd, dvd_nxt;
   logic [DATA_W-1:0]     dsr, dsr_nxt;
   logic                  sign1, sign1_nxt;
   logic                  sign2, sign2_nxt;
   logic                  sgn_mode, sgn_mode_nxt;
   logic [2*DATA_W-1:0]   result_q, result_nxt;
   logic                  ready_q, ready_nxt;

   logic [DATA_W:0]       trial;
   logic [DATA_W:0]       diff;
   logic                  borrow;
   logic [DATA_W-1:0]     rem_step;
   logic [DATA_W-1:0]     dvd_step;

   function automatic logic [DATA_W-1:0] neg(input logic [DATA_W-1:0] v);
      return '0 - v;
   endfunction

   function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v,
                                             input logic              is_signed);
      logic signed [DATA_W-1:0] sv;
      sv = v;
      return (is_signed && sv < 0) ? neg(v) : v;
   endfunction

   // Quotient negated on differing signs; remainder follows the dividend's sign.
   function automatic logic [2*DATA_W-1:0] sign_fix(input logic [DATA_W-1:0] q,
                                                    input logic [DATA_W-1:0] r,
                                                    input logic              is_signed,
                                                    input logic              s1,
                                                    input logic              s2);
      logic [DATA_W-1:0] qf;
      logic [DATA_W-1:0] rf;
      qf = (is_signed && (s1 ^ s2)) ? neg(q) : q;
      rf = (is_signed && s1) ? neg(r) : r;
      return {rf, qf};
   endfunction

   // The partial remainder is always below the divisor, so a (DATA_W+1)-bit
   // subtract suffices and its MSB is the borrow.
   assign trial    = {rem, dvd[DATA_W-1]};
   assign diff     = trial - {1'b0, dsr};
   assign borrow   = diff[DATA_W];
   assign rem_step = borrow ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
   assign dvd_step = {dvd[DATA_W-2:0], ~borrow};

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      rem_nxt      = rem;
      dvd_nxt      = dvd;
      dsr_nxt      = dsr;
      sign1_nxt    = sign1;
      sign2_nxt    = sign2;
      sgn_mode_nxt = sgn_mode;
      result_nxt   = result_q;
      ready_nxt    = DIV_RESULT_NOT_READY;
      case (state)
         DIV_FREE: begin
            result_nxt = '0;
            if (dif.start_i == DIV_START && !dif.annul_i) begin
               if (dif.opdata2_i == '0) begin
                  state_nxt = DIV_BY_ZERO;
               end else begin
                  state_nxt    = DIV_ON;
                  cnt_nxt      = '0;
                  rem_nxt      = '0;
                  dvd_nxt      = mag(dif.opdata1_i, dif.signed_div_i);
                  dsr_nxt      = mag(dif.opdata2_i, dif.signed_div_i);
                  sign1_nxt    = dif.opdata1_i[DATA_W-1];
                  sign2_nxt    = dif.opdata2_i[DATA_W-1];
                  sgn_mode_nxt = dif.signed_div_i;
               end
            end
         end
         DIV_BY_ZERO: begin
            state_nxt  = dif.annul_i ? DIV_FREE : DIV_END;
            result_nxt = '0;
         end
         DIV_ON: begin
            if (dif.annul_i) begin
               state_nxt  = DIV_FREE;
               result_nxt = '0;
            end else begin
               rem_nxt = rem_step;
               dvd_nxt = dvd_step;
               cnt_nxt = cnt + CNT_W'(1);
               if (cnt == CNT_W'(DATA_W - 1)) begin
                  state_nxt  = DIV_END;
                  cnt_nxt    = '0;
                  result_nxt = sign_fix(dvd_step, rem_step, sgn_mode, sign1, sign2);
               end
            end
         end
         DIV_END: begin
            if (dif.annul_i || dif.start_i == DIV_STOP) begin
               state_nxt  = DIV_FREE;
               result_nxt = '0;
            end else begin
               ready_nxt = DIV_RESULT_READY;
            end
         end
         default: begin
            state_nxt  = DIV_FREE;
            result_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state    <= DIV_FREE;
         cnt      <= '0;
         rem      <= '0;
         dvd      <= '0;
         dsr      <= '0;
         sign1    <= 1'b0;
         sign2    <= 1'b0;
         sgn_mode <= 1'b0;
         result_q <= '0;
         ready_q  <= DIV_RESULT_NOT_READY;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         rem      <= rem_nxt;
         dvd      <= dvd_nxt;
         dsr      <= dsr_nxt;
         sign1    <= sign1_nxt;
         sign2    <= sign2_nxt;
         sgn_mode <= sgn_mode_nxt;
         result_q <= result_nxt;
         ready_q  <= ready_nxt;
      end
   end

   assign dif.result_o = result_q;
   assign dif.ready_o  = ready_q;

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: drivers push expected {rem, quo} and latency, a monitor pops on ready_o rising.
module tb_ex_div;

   localparam int DATA_W  = 32;
   localparam int LAT_DIV = 34;  // issue negedge to first negedge with ready_o high
   localparam int LAT_DZ  = 3;

   typedef struct {
      logic [2*DATA_W-1:0] res;
      int                  lat;
      int                  issue;
      int                  id;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic mon_prev = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ex_div_if #(.DATA_W(DATA_W)) dif();

   ex_div #(.DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .dif (dif.slave)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: one scoreboard entry per rising ready_o.
   initial begin
      forever begin
         @(negedge clk);
         if (dif.ready_o && !mon_prev) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ready: got ready_o=1 result %h expected no result", dif.result_o);
            end else begin
               mon_e = sb.pop_front();
               check($sformatf("result_%0d", mon_e.id), dif.result_o, mon_e.res);
               check($sformatf("latency_%0d", mon_e.id), 64'(cyc - mon_e.issue), 64'(mon_e.lat));
            end
         end
         mon_prev = dif.ready_o;
      end
   end

   task automatic push_exp(input int id, input logic [DATA_W-1:0] b, input logic [2*DATA_W-1:0] res);
      exp_t e;
      e.res   = res;
      e.lat   = (b == '0) ? LAT_DZ : LAT_DIV;
      e.issue = cyc;
      e.id    = id;
      sb.push_back(e);
   endtask

   task automatic issue(input int id, input logic sgn, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b, input logic [2*DATA_W-1:0] res);
      dif.signed_div_i = sgn;
      dif.opdata1_i    = a;
      dif.opdata2_i    = b;
      dif.start_i      = 1'b1;
      push_exp(id, b, res);
   endtask

   // Wait for ready (bounded), then release by dropping start or raising annul.
   task automatic complete(input int id, input logic scramble, input logic use_annul);
      @(negedge clk);
      if (scramble) begin
         dif.opdata1_i    = $urandom;
         dif.opdata2_i    = $urandom;
         dif.signed_div_i = ~dif.signed_div_i;
      end
      for (int i = 0; i < 60 && !dif.ready_o; i++) @(negedge clk);
      if (!dif.ready_o) begin
         checks++;
         errors++;
         $display("FAIL timeout_%0d: got ready_o=0 expected ready within 60 cycles", id);
      end
      if (use_annul) dif.annul_i = 1'b1;
      else           dif.start_i = 1'b0;
      @(negedge clk);
      check($sformatf("release_ready_%0d", id), 64'(dif.ready_o), 64'(0));
      check($sformatf("release_result_%0d", id), dif.result_o, 64'(0));
      dif.start_i = 1'b0;
      dif.annul_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_div(input int id, input logic sgn, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input logic [2*DATA_W-1:0] res);
      issue(id, sgn, a, b, res);
      complete(id, 1'b1, 1'b0);
   endtask

   initial begin
      int rc;
      dif.signed_div_i = 1'b0;
      dif.opdata1_i    = '0;
      dif.opdata2_i    = '0;
      dif.start_i      = 1'b0;
      dif.annul_i      = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ready", 64'(dif.ready_o), 64'(0));
      check("reset_result", dif.result_o, 64'(0));
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready", 64'(dif.ready_o), 64'(0));

      do_div(1,  1'b0, 32'd100,       32'd7,         64'h00000002_0000000E);
      do_div(2,  1'b1, 32'hFFFFFFF9,  32'd2,         64'hFFFFFFFF_FFFFFFFD);
      do_div(3,  1'b1, 32'd7,         32'hFFFFFFFE,  64'h00000001_FFFFFFFD);
      do_div(4,  1'b0, 32'd1234,      32'd0,         64'h0);
      do_div(5,  1'b1, 32'hFFFFFFF9,  32'd0,         64'h0);
      do_div(6,  1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000);
      do_div(7,  1'b0, 32'h80000000,  32'hFFFFFFFF,  64'h80000000_00000000);
      do_div(8,  1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  64'hFFFFFFFE_0000000E);
      do_div(9,  1'b0, 32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF);
      do_div(10, 1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'h00000000_00000001);
      do_div(11, 1'b1, 32'd5,         32'd10,        64'h00000005_00000000);

      // Abort at cycle 10 of an in-flight division.
      dif.signed_div_i = 1'b0;
      dif.opdata1_i    = 32'd1000;
      dif.opdata2_i    = 32'd3;
      dif.start_i      = 1'b1;
      @(negedge clk);
      repeat (10) @(negedge clk);
      dif.annul_i = 1'b1;
      dif.start_i = 1'b0;
      @(negedge clk);
      dif.annul_i = 1'b0;
      rc = 0;
      repeat (40) begin
         @(negedge clk);
         if (dif.ready_o) rc++;
      end
      check("annul_on_no_ready", 64'(rc), 64'(0));
      do_div(12, 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

      // Annul held in the idle state blocks a start.
      dif.opdata1_i = 32'd9;
      dif.opdata2_i = 32'd3;
      dif.start_i   = 1'b1;
      dif.annul_i   = 1'b1;
      rc = 0;
      repeat (40) begin
         @(negedge clk);
         if (dif.ready_o) rc++;
      end
      check("annul_free_no_ready", 64'(rc), 64'(0));
      dif.start_i = 1'b0;
      dif.annul_i = 1'b0;
      @(negedge clk);

      // Annul as the release while the result is presented.
      issue(13, 1'b0, 32'd50, 32'd8, 64'h00000002_00000006);
      complete(13, 1'b1, 1'b1);

      // Reset mid-division with start held; the restart must run the full iteration count.
      dif.signed_div_i = 1'b0;
      dif.opdata1_i    = 32'd100;
      dif.opdata2_i    = 32'd7;
      dif.start_i      = 1'b1;
      @(negedge clk);
      repeat (15) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_ready", 64'(dif.ready_o), 64'(0));
      check("midrst_result", dif.result_o, 64'(0));
      rst = 1'b0;
      push_exp(14, 32'd7, 64'h00000002_0000000E);
      complete(14, 1'b0, 1'b0);

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 64'(sb.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
